// File: rtl/attractor_classifier.sv
// Settles a state trajectory onto its attractor, measures its period and reports a canonical id.
// Optional macro ATTR_MIN_EN: attr_id becomes the smallest state seen on the attractor cycle.
module attractor_classifier #(
  parameter int W          = 8,
  parameter int SETTLE_CYC = 256,
  parameter int MAX_PERIOD = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  output logic         busy,
  output logic         done,
  output logic         fixed,
  output logic         cycle,
  output logic         timeout,
  output logic [W:0]   period,
  output logic [W-1:0] attr_id
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [W:0]    K_MAX       = (W+1)'(MAX_PERIOD);
  localparam logic [W:0]    K_ONE       = (W+1)'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, ANCHOR, MEASURE} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [W-1:0]    anchor_reg, anchor_next;
  logic [W:0]      k_reg, k_next;
  logic            done_reg, done_next;
  logic            fixed_reg, fixed_next;
  logic            cycle_reg, cycle_next;
  logic            timeout_reg, timeout_next;
  logic [W:0]      period_reg, period_next;
  logic [W-1:0]    attr_reg, attr_next;
`ifdef ATTR_MIN_EN
  logic [W-1:0]    min_reg, min_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= '0;
      anchor_reg     <= '0;
      k_reg          <= '0;
      done_reg       <= 1'b0;
      fixed_reg      <= 1'b0;
      cycle_reg      <= 1'b0;
      timeout_reg    <= 1'b0;
      period_reg     <= '0;
      attr_reg       <= '0;
`ifdef ATTR_MIN_EN
      min_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      anchor_reg     <= anchor_next;
      k_reg          <= k_next;
      done_reg       <= done_next;
      fixed_reg      <= fixed_next;
      cycle_reg      <= cycle_next;
      timeout_reg    <= timeout_next;
      period_reg     <= period_next;
      attr_reg       <= attr_next;
`ifdef ATTR_MIN_EN
      min_reg        <= min_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    anchor_next     = anchor_reg;
    k_next          = k_reg;
    done_next       = 1'b0;
    fixed_next      = fixed_reg;
    cycle_next      = cycle_reg;
    timeout_next    = timeout_reg;
    period_next     = period_reg;
    attr_next       = attr_reg;
`ifdef ATTR_MIN_EN
    min_next        = min_reg;
`endif
    // A start always (re)launches a run, aborting any run in flight and suppressing its done.
    if (start) begin
      state_next      = SETTLE;
      settle_cnt_next = '0;
      fixed_next      = 1'b0;
      cycle_next      = 1'b0;
      timeout_next    = 1'b0;
      period_next     = '0;
      attr_next       = '0;
    end else begin
      case (state_reg)
        IDLE: ;
        SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) state_next = ANCHOR;
          else                               settle_cnt_next = settle_cnt_reg + 1'b1;
        end
        ANCHOR: begin
          anchor_next = x;
          k_next      = K_ONE;
`ifdef ATTR_MIN_EN
          min_next    = x;
`endif
          state_next  = MEASURE;
        end
        MEASURE: begin
          if (x == anchor_reg) begin
            period_next = k_reg;
            fixed_next  = (k_reg == K_ONE);
            cycle_next  = (k_reg > K_ONE);
`ifdef ATTR_MIN_EN
            attr_next   = min_reg;
`else
            attr_next   = anchor_reg;
`endif
            done_next   = 1'b1;
            state_next  = IDLE;
          end else if (k_reg == K_MAX) begin
            timeout_next = 1'b1;
            period_next  = '0;
            attr_next    = anchor_reg;
            done_next    = 1'b1;
            state_next   = IDLE;
          end else begin
            k_next = k_reg + 1'b1;
`ifdef ATTR_MIN_EN
            if (x < min_reg) min_next = x;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign fixed   = fixed_reg;
  assign cycle   = cycle_reg;
  assign timeout = timeout_reg;
  assign period  = period_reg;
  assign attr_id = attr_reg;

endmodule

// File: tb/tb_attractor_classifier.sv
// Directed bench for attractor_classifier: scripted x streams, scoreboard of expected done results.
module tb_attractor_classifier;

`ifdef ATTR_MIN_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif

  typedef struct {
    int         done_edge;
    logic       fixed;
    logic       cycle;
    logic       timeout;
    logic [8:0] period;
    logic [7:0] attr;
  } exp_t;

  logic clk, rst_n;
  logic start_a, start_b, start_c;
  logic [7:0] x;
  logic busy_a, done_a, fixed_a, cycle_a, timeout_a;
  logic busy_b, done_b, fixed_b, cycle_b, timeout_b;
  logic busy_c, done_c, fixed_c, cycle_c, timeout_c;
  logic [8:0] period_a, period_b, period_c;
  logic [7:0] attr_a, attr_b, attr_c;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  logic [7:0] seq [8];
  int seq_len;

  attractor_classifier #(.W(8), .SETTLE_CYC(8), .MAX_PERIOD(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x(x), .busy(busy_a), .done(done_a),
    .fixed(fixed_a), .cycle(cycle_a), .timeout(timeout_a), .period(period_a), .attr_id(attr_a));

  attractor_classifier #(.W(8), .SETTLE_CYC(8), .MAX_PERIOD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x(x), .busy(busy_b), .done(done_b),
    .fixed(fixed_b), .cycle(cycle_b), .timeout(timeout_b), .period(period_b), .attr_id(attr_b));

  attractor_classifier dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .x(x), .busy(busy_c), .done(done_c),
    .fixed(fixed_c), .cycle(cycle_c), .timeout(timeout_c), .period(period_c), .attr_id(attr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int de, input logic f, input logic c, input logic t,
                              input logic [8:0] p, input logic [7:0] a);
    exp_t e;
    e.done_edge = de; e.fixed = f; e.cycle = c; e.timeout = t; e.period = p; e.attr = a;
    return e;
  endfunction

  task automatic cmp(input string n, input exp_t e, input int ed, input logic f, input logic c,
                     input logic t, input logic [8:0] p, input logic [7:0] a);
    chk({n, " done_edge"}, ed, e.done_edge);
    chk({n, " fixed"}, {31'd0, f}, {31'd0, e.fixed});
    chk({n, " cycle"}, {31'd0, c}, {31'd0, e.cycle});
    chk({n, " timeout"}, {31'd0, t}, {31'd0, e.timeout});
    chk({n, " period"}, {23'd0, p}, {23'd0, e.period});
    chk({n, " attr_id"}, {24'd0, a}, {24'd0, e.attr});
    $display("done %s edge=%0d period=%0d fixed=%0b cycle=%0b timeout=%0b attr=%02h",
             n, ed, p, f, c, t, a);
  endtask

  // Scoreboard: every done pops the oldest expectation of its instance.
  always @(negedge clk) begin
    if (done_a) begin
      chk("sb_a has entry at done", {31'd0, q_a.size() > 0}, 32'd1);
      if (q_a.size() > 0) cmp("a", q_a.pop_front(), edge_n, fixed_a, cycle_a, timeout_a, period_a, attr_a);
    end
    if (done_b) begin
      chk("sb_b has entry at done", {31'd0, q_b.size() > 0}, 32'd1);
      if (q_b.size() > 0) cmp("b", q_b.pop_front(), edge_n, fixed_b, cycle_b, timeout_b, period_b, attr_b);
    end
    if (done_c) begin
      chk("sb_c has entry at done", {31'd0, q_c.size() > 0}, 32'd1);
      if (q_c.size() > 0) cmp("c", q_c.pop_front(), edge_n, fixed_c, cycle_c, timeout_c, period_c, attr_c);
    end
  end

  // Drives the inputs sampled at the next rising edge; x follows seq indexed by edge number.
  task automatic tick(input logic sa, input logic sb, input logic sc);
    @(negedge clk);
    x = seq[(edge_n + 1) % seq_len];
    start_a = sa; start_b = sb; start_c = sc;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && i < budget) begin
      tick(1'b0, 1'b0, 1'b0);
      i++;
    end
    chk("pending results after wait", q_a.size() + q_b.size() + q_c.size(), 32'd0);
  endtask

  initial begin
    int se, se2;
    logic [7:0] anchor;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; x = 8'h00;
    seq = '{default: 8'h00}; seq_len = 1;
    #1;
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset done", {31'd0, done_a}, 32'd0);
    chk("reset fixed", {31'd0, fixed_a}, 32'd0);
    chk("reset cycle", {31'd0, cycle_a}, 32'd0);
    chk("reset timeout", {31'd0, timeout_a}, 32'd0);
    chk("reset period", {23'd0, period_a}, 32'd0);
    chk("reset attr_id", {24'd0, attr_a}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Fixed point 0x53
    seq[0] = 8'h53; seq_len = 1;
    tick(1'b1, 1'b0, 1'b0); se = edge_n + 1;
    q_a.push_back(mk(se + 10, 1'b1, 1'b0, 1'b0, 9'd1, 8'h53));
    tick(1'b0, 1'b0, 1'b0);
    chk("t1 busy after start", {31'd0, busy_a}, 32'd1);
    wait_done(40);

    // Period-3 cycle B2,40,1C
    seq = '{8'hB2, 8'h40, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; seq_len = 3;
    tick(1'b1, 1'b0, 1'b0); se = edge_n + 1;
    anchor = seq[(se + 9) % 3];
    q_a.push_back(mk(se + 12, 1'b0, 1'b1, 1'b0, 9'd3, MIN_EN ? 8'h1C : anchor));
    wait_done(40);

    // Period 5 against MAX_PERIOD=4
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00}; seq_len = 5;
    tick(1'b0, 1'b1, 1'b0); se = edge_n + 1;
    anchor = seq[(se + 9) % 5];
    q_b.push_back(mk(se + 13, 1'b0, 1'b0, 1'b1, 9'd0, anchor));
    wait_done(40);

    // Restart 5 cycles into MEASURE on a period-7 cycle
    seq = '{8'h70, 8'h22, 8'h91, 8'h15, 8'h66, 8'h38, 8'h4A, 8'h00}; seq_len = 7;
    tick(1'b1, 1'b0, 1'b0); se = edge_n + 1;
    for (int i = 0; i < 13; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk("t4 busy before restart", {31'd0, busy_a}, 32'd1);
    end
    tick(1'b1, 1'b0, 1'b0); se2 = edge_n + 1;
    anchor = seq[(se2 + 9) % 7];
    q_a.push_back(mk(se2 + 16, 1'b0, 1'b1, 1'b0, 9'd7, MIN_EN ? 8'h15 : anchor));
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk("t4 busy after restart", {31'd0, busy_a}, 32'd1);
    end
    wait_done(20);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("hold period", {23'd0, period_a}, 32'd7);
    chk("hold cycle", {31'd0, cycle_a}, 32'd1);

    // Reset during SETTLE, then a normal run
    seq[0] = 8'h53; seq_len = 1;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("start clears period", {23'd0, period_a}, 32'd0);
    chk("start clears cycle", {31'd0, cycle_a}, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-run reset busy", {31'd0, busy_a}, 32'd0);
    chk("mid-run reset done", {31'd0, done_a}, 32'd0);
    chk("mid-run reset period", {23'd0, period_a}, 32'd0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (20) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0); se = edge_n + 1;
    q_a.push_back(mk(se + 10, 1'b1, 1'b0, 1'b0, 9'd1, 8'h53));
    wait_done(40);

    // Start coinciding with the match edge: restart wins
    tick(1'b1, 1'b0, 1'b0); se = edge_n + 1;
    repeat (9) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0); se2 = edge_n + 1;
    chk("t6 start on match edge", se2 - se, 32'd10);
    q_a.push_back(mk(se2 + 10, 1'b1, 1'b0, 1'b0, 9'd1, 8'h53));
    wait_done(40);

    // Default parameters, state stuck at 0x00
    seq[0] = 8'h00; seq_len = 1;
    tick(1'b0, 1'b0, 1'b1); se = edge_n + 1;
    q_c.push_back(mk(se + 258, 1'b1, 1'b0, 1'b0, 9'd1, 8'h00));
    wait_done(300);

    repeat (3) tick(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
